// File: rtl/restoring_divider16.sv
// restoring_divider16
// -------------------
// 16-bit unsigned restoring divider. Each CALC cycle produces one quotient bit.
// Divide-by-zero skips CALC and reports a fixed result with DivByZero set.
//
// Ports:
//   Clk          in   1   rising-edge clock
//   Reset        in   1   synchronous, active-high reset
//   Run          in   1   start request, level sampled, accepted only in IDLE
//   Dividend     in  16   numerator, captured on the accept edge
//   Divisor      in  16   denominator, captured on the accept edge
//   Quotient     out 16   registered quotient of the last completed operation
//   Remainder    out 16   registered remainder of the last completed operation
//   Done         out  1   high while in DONE
//   Busy         out  1   high while in CALC
//   DivByZero    out  1   high when the last operation had Divisor = 0
//   dbg_state_o  out  2   current FSM state (0 IDLE, 1 CALC, 2 DONE)
//
// Handshake: Run is a level. In IDLE a high Run starts one operation; the block
// then stays in DONE until Run is seen low, so a Run held high yields exactly
// one operation. Run is ignored during CALC.

module restoring_divider16 (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Run,
    input  logic [15:0] Dividend,
    input  logic [15:0] Divisor,
    output logic [15:0] Quotient,
    output logic [15:0] Remainder,
    output logic        Done,
    output logic        Busy,
    output logic        DivByZero,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [15:0] q_q, q_d;
    logic [15:0] r_q, r_d;
    logic [15:0] d_q, d_d;
    logic [15:0] quotient_q, quotient_d;
    logic [15:0] remainder_q, remainder_d;
    logic        dbz_q, dbz_d;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and try to subtract the divisor. Bit 16 of diff is the borrow.
    logic [15:0] r_shift;
    logic [16:0] diff;
    logic [15:0] r_step;
    logic [15:0] q_step;

    always_comb begin
        r_shift = {r_q[14:0], q_q[15]};
        diff    = {1'b0, r_shift} - {1'b0, d_q};
        if (diff[16] == 1'b0) begin
            r_step = diff[15:0];
            q_step = {q_q[14:0], 1'b1};
        end else begin
            r_step = r_shift;
            q_step = {q_q[14:0], 1'b0};
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        q_d         = q_q;
        r_d         = r_q;
        d_d         = d_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (Run) begin
                    if (Divisor != 16'd0) begin
                        q_d     = Dividend;
                        r_d     = 16'd0;
                        d_d     = Divisor;
                        count_d = 4'd0;
                        state_d = S_CALC;
                    end else begin
                        quotient_d  = 16'hFFFF;
                        remainder_d = Dividend;
                        dbz_d       = 1'b1;
                        state_d     = S_DONE;
                    end
                end
            end

            S_CALC: begin
                q_d     = q_step;
                r_d     = r_step;
                count_d = count_q + 4'd1;
                // The result of the last step goes straight to the outputs,
                // so Quotient/Remainder never show a partial value.
                if (count_q == 4'd15) begin
                    quotient_d  = q_step;
                    remainder_d = r_step;
                    dbz_d       = 1'b0;
                    state_d     = S_DONE;
                end
            end

            S_DONE: begin
                if (!Run) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            count_q     <= 4'd0;
            q_q         <= 16'd0;
            r_q         <= 16'd0;
            d_q         <= 16'd0;
            quotient_q  <= 16'd0;
            remainder_q <= 16'd0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            q_q         <= q_d;
            r_q         <= r_d;
            d_q         <= d_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign Quotient    = quotient_q;
    assign Remainder   = remainder_q;
    assign DivByZero   = dbz_q;
    assign Done        = (state_q == S_DONE);
    assign Busy        = (state_q == S_CALC);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_restoring_divider16.sv
// tb_restoring_divider16
// ----------------------
// Table-driven vectors plus random operations, each pushing its expected
// {DivByZero, Quotient, Remainder} into a queue that is popped when Done
// rises. Hand-written sequences cover reset mid-CALC and Run held high.

module tb_restoring_divider16;

    logic        clk;
    logic        reset;
    logic        run;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        done;
    logic        busy;
    logic        div_by_zero;
    logic [1:0]  dbg_state;

    restoring_divider16 dut (
        .Clk         (clk),
        .Reset       (reset),
        .Run         (run),
        .Dividend    (dividend),
        .Divisor     (divisor),
        .Quotient    (quotient),
        .Remainder   (remainder),
        .Done        (done),
        .Busy        (busy),
        .DivByZero   (div_by_zero),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
        int          hold;
    } vec_t;

    vec_t        vecs[10];
    logic [32:0] exp_q[$];
    int          n_checks;
    int          n_errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // hold = number of edges Run stays high after the accept edge.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input logic [15:0] er,
                         input logic ez, input int hold);
        logic [15:0] pq, pr;
        logic        pz;
        logic [32:0] e;
        int          edges, busy_n, rises;
        bit          stable, both, done_seen, prev_done, held;

        @(negedge clk);
        pq = quotient;
        pr = remainder;
        pz = div_by_zero;
        run      = 1'b1;
        dividend = a;
        divisor  = b;
        exp_q.push_back({ez, eq, er});

        edges = 0; busy_n = 0; rises = 0;
        stable = 1'b1; both = 1'b0; done_seen = 1'b0; prev_done = 1'b0; held = 1'b1;

        while (!done_seen && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (edges >= hold + 1) run = 1'b0;
            // Operands move after the accept edge; the result must not care.
            if (edges == 3) begin
                dividend = 16'($urandom);
                divisor  = 16'($urandom);
            end
            if (busy) busy_n++;
            if (busy && done) both = 1'b1;
            if (done && !prev_done) rises++;
            prev_done = done;
            if (done) done_seen = 1'b1;
            else if ({quotient, remainder, div_by_zero} !== {pq, pr, pz}) stable = 1'b0;
        end

        check("latency", edges, ez ? 32'd1 : 32'd17);
        e = exp_q.pop_front();
        check("quotient",  {16'd0, quotient},  {16'd0, e[31:16]});
        check("remainder", {16'd0, remainder}, {16'd0, e[15:0]});
        check("divbyzero", {31'd0, div_by_zero}, {31'd0, e[32]});
        if (b != 16'd0) begin
            check("identity", {16'd0, quotient} * {16'd0, b} + {16'd0, remainder}, {16'd0, a});
            check("rem_lt_div", {31'd0, (remainder < b)}, 32'd1);
        end

        while (run && edges < 100) begin
            @(posedge clk); #1;
            edges++;
            if (!done) held = 1'b0;
            if (done && !prev_done) rises++;
            prev_done = done;
            if (busy && done) both = 1'b1;
            if (edges >= hold + 1) run = 1'b0;
        end
        check("done_held", {31'd0, held}, 32'd1);

        @(posedge clk); #1;
        check("return_idle", {28'd0, done, busy, dbg_state}, 32'd0);
        check("done_rises", rises, 32'd1);
        check("busy_cycles", busy_n, ez ? 32'd0 : 32'd16);
        check("busy_done_excl", {31'd0, both}, 32'd0);
        check("hold_in_calc", {31'd0, stable}, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] a, b;
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        run      = 1'b0;
        dividend = 16'd0;
        divisor  = 16'd0;

        vecs[0] = '{16'd100,   16'd7,     16'd14,    16'd2,   1'b0, 0};
        vecs[1] = '{16'hFFFF,  16'd1,     16'hFFFF,  16'd0,   1'b0, 0};
        vecs[2] = '{16'hFFFF,  16'hFFFF,  16'd1,     16'd0,   1'b0, 0};
        vecs[3] = '{16'd5,     16'd0,     16'hFFFF,  16'd5,   1'b1, 0};
        vecs[4] = '{16'd3,     16'd10,    16'd0,     16'd3,   1'b0, 0};
        vecs[5] = '{16'd0,     16'd5,     16'd0,     16'd0,   1'b0, 0};
        vecs[6] = '{16'd65535, 16'd256,   16'd255,   16'd255, 1'b0, 0};
        vecs[7] = '{16'd32768, 16'd3,     16'd10922, 16'd2,   1'b0, 0};
        vecs[8] = '{16'd12345, 16'd123,   16'd100,   16'd45,  1'b0, 0};
        vecs[9] = '{16'd50000, 16'd123,   16'd406,   16'd62,  1'b0, 40};

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {quotient, remainder}, 32'd0);
        check("reset_flags", {28'd0, done, busy, div_by_zero, dbg_state[0]}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, vecs[i].hold);
        end

        for (int i = 0; i < 8; i++) begin
            a = 16'($urandom_range(0, 65535));
            b = (i == 0) ? 16'd0 : 16'($urandom_range(1, 65535) >> $urandom_range(0, 15));
            if (b == 16'd0) do_op(a, b, 16'hFFFF, a, 1'b1, 0);
            else            do_op(a, b, a / b, a % b, 1'b0, $urandom_range(0, 3));
        end

        // Reset in the middle of CALC: nonzero result first, then abort.
        do_op(16'd1000, 16'd33, 16'd30, 16'd10, 1'b0, 0);
        @(negedge clk);
        run      = 1'b1;
        dividend = 16'd100;
        divisor  = 16'd7;
        @(posedge clk); #1;
        run = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("mid_calc_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_outputs", {quotient, remainder}, 32'd0);
        check("abort_flags", {28'd0, done, busy, div_by_zero, 1'b0}, 32'd0);
        check("abort_state", {30'd0, dbg_state}, 32'd0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_abort", {quotient, remainder}, 32'd0);
        do_op(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 0);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/restoring_divider16.md
RESTORING_DIVIDER16 -- requirements
Module: restoring_divider16

Interface
REQ-001 The module SHALL have no parameters; the datapath is fixed at 16 bits, unsigned.
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset, sampled on rising Clk edge.
REQ-004 Run  input  1  start request, level-sampled; accepted only in IDLE.
REQ-005 Dividend  input  16  unsigned numerator, sampled on the Run-accept edge.
REQ-006 Divisor  input  16  unsigned denominator, sampled on the Run-accept edge.
REQ-007 Quotient  output  16  registered quotient of last completed operation.
REQ-008 Remainder  output  16  registered remainder of last completed operation.
REQ-009 Done  output  1  high while in DONE state.
REQ-010 Busy  output  1  high while in CALC state.
REQ-011 DivByZero  output  1  high with Done when the operation had Divisor = 0.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-013 IDLE: on an edge with Run = 1 and Divisor != 0, the block SHALL latch the operands into internal registers (Q <= Dividend, R <= 0, D <= Divisor), clear count to 0 and go to CALC.
REQ-014 IDLE: on an edge with Run = 1 and Divisor = 0, the block SHALL go directly to DONE with Quotient = 16'hFFFF, Remainder = Dividend and DivByZero = 1.
REQ-015 CALC, each edge: the block SHALL form R' = {R[14:0], Q[15]} and compute the 17-bit diff = {1'b0, R'} - {1'b0, D}.
REQ-016 CALC, same edge: if diff[16] = 0 (no borrow), the block SHALL set R <= diff[15:0] and Q <= {Q[14:0], 1}; otherwise it SHALL set R <= R' and Q <= {Q[14:0], 0}.
REQ-017 CALC SHALL last exactly 16 edges (count 0..15); on the edge with count = 15, the block SHALL load Quotient and Remainder from the final Q and R, set DivByZero = 0 and go to DONE.
REQ-018 Latency: Done SHALL rise 17 edges after the Run-accept edge for a nonzero divisor, and 1 edge after it for a zero divisor.
REQ-019 Quotient, Remainder and DivByZero SHALL hold their previous values throughout CALC and change only on entry to DONE or on Reset.
REQ-020 Run SHALL be ignored during CALC; Dividend and Divisor changes after the accept edge SHALL NOT affect the result.
REQ-021 DONE: the block SHALL remain in DONE while Run = 1 and return to IDLE on the first edge with Run = 0; holding Run high SHALL yield exactly one operation.
REQ-022 Done and Busy SHALL never both be 1; both SHALL be 0 in IDLE.
REQ-023 Results SHALL satisfy Dividend = Quotient*Divisor + Remainder, with Remainder < Divisor, for every nonzero Divisor.

Reset
REQ-024 Reset SHALL take priority over all other inputs in every state, including mid-CALC.
REQ-025 On Reset the block SHALL enter IDLE, clear count, Q, R and D, and drive Quotient = 0, Remainder = 0, Done = 0, Busy = 0 and DivByZero = 0.
REQ-026 After Reset deasserts, a Run = 1 edge SHALL start a new operation normally; no partial result of an aborted operation SHALL appear on the outputs.

Verification
REQ-027 Dividend = 100, Divisor = 7, Run pulsed -> Busy for 16 cycles, Done at edge 17, Quotient = 14, Remainder = 2, DivByZero = 0.
REQ-028 Dividend = 16'hFFFF, Divisor = 1 -> Quotient = 16'hFFFF, Remainder = 0; then 16'hFFFF / 16'hFFFF -> Quotient = 1, Remainder = 0.
REQ-029 Dividend = 5, Divisor = 0 -> Done at edge 1, Quotient = 16'hFFFF, Remainder = 5, DivByZero = 1, Busy never 1.
REQ-030 Dividend = 3, Divisor = 10 -> Quotient = 0, Remainder = 3; prior results stay stable during CALC.
REQ-031 Reset asserted at CALC count = 8 -> next cycle all outputs are 0 and the state is IDLE; a following 100 / 7 run yields 14 r 2.
REQ-032 Run held high for 40 cycles, with operands changed mid-CALC -> exactly one Done, the result matches the accept-edge operands, and the block returns to IDLE one edge after Run falls.
